// File: rtl/score_renderer.sv
// Piano-roll pixel renderer: double-buffered note table, song-position counter and a
// fixed two-stage pixel pipeline that returns one RGB value per (x, y) request.
module score_renderer #(
    parameter int SCREEN_WIDTH    = 800,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int SCREEN_START_X  = 88,
    parameter int SCREEN_START_Y  = 32,
    parameter int X_BITS          = 11,
    parameter int Y_BITS          = 10,
    parameter int DISPLAYED_BEATS = 8,
    parameter int MAX_NOTES       = 16,
    parameter int NOTE_BITS       = 6,
    parameter int BEAT_BITS       = 8,
    parameter int BEAT_DURATION   = 1000000,
    parameter int CHANNELS        = 2,
    localparam int CH_BITS        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 restart,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [X_BITS-1:0]    x,
    input  logic [Y_BITS-1:0]    y,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [NOTE_BITS-1:0] wr_note,
    input  logic [BEAT_BITS-1:0] wr_start,
    input  logic [BEAT_BITS-1:0] wr_dur,
    input  logic [CH_BITS-1:0]   wr_channel,
    input  logic                 wr_last,
    output logic                 out_valid,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic [BEAT_BITS-1:0] cur_beat,
    output logic                 overflow
);
    localparam int BEAT_PX  = SCREEN_WIDTH / DISPLAYED_BEATS;
    localparam int NOTE_PX  = SCREEN_HEIGHT / (2 ** NOTE_BITS);
    localparam int PH_BITS  = (BEAT_DURATION > 1) ? $clog2(BEAT_DURATION) : 1;
    localparam int IDX_BITS = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int CNT_BITS = $clog2(MAX_NOTES + 1);

    typedef struct packed {
        logic [NOTE_BITS-1:0] note;
        logic [BEAT_BITS-1:0] start;
        logic [BEAT_BITS-1:0] dur;
        logic [CH_BITS-1:0]   ch;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FILL, PENDING} load_state_t;

    // Song position
    logic [PH_BITS-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            cur_beat <= '0;
        end else if (restart) begin
            phase    <= '0;
            cur_beat <= '0;
        end else if (run) begin
            if (phase == PH_BITS'(BEAT_DURATION - 1)) begin
                phase    <= '0;
                cur_beat <= cur_beat + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Loader FSM
    load_state_t state, state_next;
    logic        swap;
    logic        accept;
    logic        store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b1;
        swap       = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (wr_valid) state_next = wr_last ? PENDING : FILL;
            end
            PENDING: begin
                wr_ready = 1'b0;
                if (frame_start) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic                 active_bank;
    logic [CNT_BITS-1:0]  shadow_count;
    logic [CNT_BITS-1:0]  active_count;
    logic [BEAT_BITS-1:0] snap_beat;

    assign accept = wr_valid && wr_ready;
    assign store  = accept && (shadow_count < CNT_BITS'(MAX_NOTES));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bank  <= 1'b0;
            shadow_count <= '0;
            active_count <= '0;
            snap_beat    <= '0;
            overflow     <= 1'b0;
        end else begin
            if (frame_start) snap_beat <= cur_beat;
            if (swap) begin
                active_bank  <= ~active_bank;
                active_count <= shadow_count;
                shadow_count <= '0;
            end else if (store) begin
                shadow_count <= shadow_count + 1'b1;
            end else if (accept) begin
                overflow <= 1'b1;
            end
        end
    end

    entry_t table_mem [2][MAX_NOTES];

    // NOTE: the table has no reset; active_count gates every read, so stale entries never show.
    always_ff @(posedge clk) begin
        if (store)
            table_mem[~active_bank][shadow_count[IDX_BITS-1:0]] <=
                '{note: wr_note, start: wr_start, dur: wr_dur, ch: wr_channel};
    end

    // Stage 1: window test and screen-relative coordinates
    logic              s1_valid;
    logic              s1_in_window;
    logic [X_BITS-1:0] s1_rx;
    logic [Y_BITS-1:0] s1_ry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_in_window <= 1'b0;
            s1_rx        <= '0;
            s1_ry        <= '0;
        end else begin
            s1_valid     <= pix_valid;
            s1_in_window <= (x >= X_BITS'(SCREEN_START_X)) &&
                            (x <  X_BITS'(SCREEN_START_X + SCREEN_WIDTH)) &&
                            (y >= Y_BITS'(SCREEN_START_Y)) &&
                            (y <  Y_BITS'(SCREEN_START_Y + SCREEN_HEIGHT));
            s1_rx        <= x - X_BITS'(SCREEN_START_X);
            s1_ry        <= y - Y_BITS'(SCREEN_START_Y);
        end
    end

    // Beat offsets are signed so notes that began before the snapshot clamp to column 0.
    function automatic logic entry_hit(input entry_t ent, input logic [BEAT_BITS-1:0] snap,
                                       input logic [X_BITS-1:0] rx, input logic [Y_BITS-1:0] ry);
        logic signed [BEAT_BITS+1:0] d;
        logic signed [BEAT_BITS+1:0] e;
        int col_lo;
        int col_hi;
        int row_lo;
        d      = $signed({2'b00, ent.start}) - $signed({2'b00, snap});
        e      = $signed({2'b00, ent.start}) + $signed({2'b00, ent.dur}) - $signed({2'b00, snap});
        col_lo = (d < 0) ? 0 : int'(d) * BEAT_PX;
        col_hi = (e > DISPLAYED_BEATS) ? DISPLAYED_BEATS * BEAT_PX : int'(e) * BEAT_PX;
        row_lo = ((2 ** NOTE_BITS) - 1 - int'(ent.note)) * NOTE_PX;
        return (ent.dur != '0) && (int'(rx) >= col_lo) && (int'(rx) < col_hi) &&
               (int'(ry) >= row_lo) && (int'(ry) < row_lo + NOTE_PX);
    endfunction

    function automatic logic [23:0] palette(input logic [1:0] ch);
        case (ch)
            2'd0:    return 24'h00C000;
            2'd1:    return 24'h0040FF;
            2'd2:    return 24'hFF8000;
            default: return 24'hC000C0;
        endcase
    endfunction

    // Stage 2: hit test; scanning downwards lets the lowest matching index win.
    logic       hit;
    logic [1:0] hit_ch;

    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = MAX_NOTES - 1; i >= 0; i--) begin
            if (i < int'(active_count) &&
                entry_hit(table_mem[active_bank][i], snap_beat, s1_rx, s1_ry)) begin
                hit    = 1'b1;
                hit_ch = 2'(table_mem[active_bank][i].ch);
            end
        end
    end

    logic [23:0] rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rgb       <= '0;
        end else begin
            out_valid <= s1_valid;
            if (!s1_valid || !s1_in_window) rgb <= 24'h000000;
            else if (hit)                   rgb <= palette(hit_ch);
            else                            rgb <= 24'hFFFFFF;
        end
    end

    assign {r, g, b} = rgb;

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a table-and-beat model of the renderer.
module tb_score_renderer;
    localparam int BD     = 4;
    localparam int SX     = 88;
    localparam int SY     = 32;
    localparam int W      = 800;
    localparam int H      = 480;
    localparam int BPX    = 100;
    localparam int NPX    = 7;
    localparam int NMAX   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run = 0, restart = 0, frame_start = 0, pix_valid = 0;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        wr_valid = 0, wr_ready, wr_last = 0;
    logic [5:0]  wr_note = '0;
    logic [7:0]  wr_start = '0, wr_dur = '0;
    logic [0:0]  wr_channel = '0;
    logic        out_valid, overflow;
    logic [7:0]  r, g, b, cur_beat;

    score_renderer #(.BEAT_DURATION(BD)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .restart(restart), .frame_start(frame_start),
        .pix_valid(pix_valid), .x(x), .y(y), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_note(wr_note), .wr_start(wr_start), .wr_dur(wr_dur), .wr_channel(wr_channel),
        .wr_last(wr_last), .out_valid(out_valid), .r(r), .g(g), .b(b),
        .cur_beat(cur_beat), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int note; int start; int dur; int ch; } ent_t;

    ent_t        m_active[$];
    ent_t        m_shadow[$];
    int          m_beat = 0, m_phase = 0, m_snap = 0;
    bit          m_pending = 0, m_over = 0, m_acc = 0;
    bit          p1_valid = 0;
    int          p1_x = 0, p1_y = 0;
    bit          e_valid = 0;
    logic [23:0] e_rgb = '0;

    function automatic logic [23:0] pal(input int ch);
        case (ch)
            0:       return 24'h00C000;
            1:       return 24'h0040FF;
            2:       return 24'hFF8000;
            default: return 24'hC000C0;
        endcase
    endfunction

    // A pixel shows the first note sounding at the song beat under its column on its pitch row.
    function automatic logic [23:0] model_pixel(input int px, input int py);
        int col, row, beat;
        if (px < SX || px >= SX + W || py < SY || py >= SY + H) return 24'h000000;
        col  = (px - SX) / BPX;
        row  = (py - SY) / NPX;
        beat = m_snap + col;
        foreach (m_active[i])
            if (beat >= m_active[i].start && beat < m_active[i].start + m_active[i].dur &&
                row == 63 - m_active[i].note)
                return pal(m_active[i].ch);
        return 24'hFFFFFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beat = 0; m_phase = 0; m_snap = 0; m_pending = 0; m_over = 0;
            m_active.delete(); m_shadow.delete();
            p1_valid = 0; e_valid = 0; e_rgb = 24'h0;
        end else begin
            e_valid  = p1_valid;
            e_rgb    = p1_valid ? model_pixel(p1_x, p1_y) : 24'h000000;
            p1_valid = pix_valid;
            p1_x     = int'(x);
            p1_y     = int'(y);
            m_acc    = wr_valid && !m_pending;
            if (frame_start) begin
                m_snap = m_beat;
                if (m_pending) begin
                    m_active  = m_shadow;
                    m_shadow.delete();
                    m_pending = 0;
                end
            end
            if (m_acc) begin
                if (m_shadow.size() < NMAX)
                    m_shadow.push_back('{int'(wr_note), int'(wr_start), int'(wr_dur), int'(wr_channel)});
                else
                    m_over = 1;
                if (wr_last) m_pending = 1;
            end
            if (restart) begin
                m_beat = 0; m_phase = 0;
            end else if (run) begin
                m_phase++;
                if (m_phase == BD) begin
                    m_phase = 0;
                    m_beat  = (m_beat + 1) % 256;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n === 1'b1) begin
            check("pixel", {7'b0, out_valid, r, g, b}, {7'b0, e_valid, e_rgb});
            check("status", {22'b0, wr_ready, overflow, cur_beat},
                  {22'b0, ~m_pending, m_over, 8'(m_beat)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int note, input int start, input int dur, input int ch, input bit last);
        int waited = 0;
        @(negedge clk);
        while (!wr_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!wr_ready) check("wr_ready wait", 32'(wr_ready), 32'd1);
        wr_valid   = 1;
        wr_note    = 6'(note);
        wr_start   = 8'(start);
        wr_dur     = 8'(dur);
        wr_channel = 1'(ch);
        wr_last    = last;
        @(negedge clk);
        wr_valid = 0;
        wr_last  = 0;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
    endtask

    task automatic probe(input string name, input int px, input int py, input logic [23:0] exp);
        @(negedge clk);
        pix_valid = 1;
        x = 11'(px);
        y = 10'(py);
        @(negedge clk);
        pix_valid = 0;
        @(negedge clk);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check(name, 32'({r, g, b}), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset wr_ready", 32'(wr_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset rgb", 32'({r, g, b}), 32'h0);
        check("reset cur_beat", 32'(cur_beat), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1;

        // Basic draw
        wr(63, 0, 2, 0, 1);
        frame();
        probe("basic 88,32", 88, 32, 24'h00C000);
        probe("basic 288,32", 288, 32, 24'hFFFFFF);
        probe("basic 88,39", 88, 39, 24'hFFFFFF);
        probe("basic 87,32", 87, 32, 24'h000000);

        // Overflow: 17 writes, only the first 16 land
        for (int i = 0; i < 17; i++) wr(63 - i, 0, 1, 1, i == 16);
        frame();
        check("overflow flag", 32'(overflow), 32'd1);
        probe("ovf entry0", 88, 32, 24'h0040FF);
        probe("ovf entry15", 88, 32 + 15 * NPX, 24'h0040FF);
        probe("ovf entry16", 88, 32 + 16 * NPX, 24'hFFFFFF);

        // No tearing: table B stays hidden until frame_start
        wr(63, 0, 1, 0, 1);
        probe("tear before", 88, 32, 24'h0040FF);
        frame();
        probe("tear after", 88, 32, 24'h00C000);

        // Scroll
        @(negedge clk);
        run = 1;
        repeat (8) @(negedge clk);
        run = 0;
        check("scroll cur_beat", 32'(cur_beat), 32'd2);
        wr(63, 0, 2, 0, 0);
        wr(62, 2, 1, 1, 1);
        frame();
        probe("scroll old note", 88, 32, 24'hFFFFFF);
        probe("scroll 88,39", 88, 39, 24'h0040FF);
        probe("scroll 188,39", 188, 39, 24'hFFFFFF);

        // Priority and window edges
        wr(63, 2, 3, 1, 0);
        wr(63, 2, 1, 0, 1);
        frame();
        probe("priority", 88, 32, 24'h0040FF);
        probe("edge x=887", 887, 32, 24'hFFFFFF);
        probe("edge x=888", 888, 32, 24'h000000);
        probe("edge y=511", 88, 511, 24'hFFFFFF);
        probe("edge y=512", 88, 512, 24'h000000);

        // Restart with run high: beat 3, phase 1 before restart
        @(negedge clk);
        run = 1;
        repeat (5) @(negedge clk);
        check("pre-restart beat", 32'(cur_beat), 32'd3);
        restart = 1;
        @(negedge clk);
        restart = 0;
        check("restart beat", 32'(cur_beat), 32'd0);
        repeat (3) @(negedge clk);
        check("restart phase beat0", 32'(cur_beat), 32'd0);
        @(negedge clk);
        check("restart phase beat1", 32'(cur_beat), 32'd1);
        run = 0;

        // Randomized run with a mid-operation reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check("async reset wr_ready", 32'(wr_ready), 32'd1);
                check("async reset out_valid", 32'(out_valid), 32'd0);
                check("async reset rgb", 32'({r, g, b}), 32'h0);
                check("async reset cur_beat", 32'(cur_beat), 32'd0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            wr_valid    = ($urandom % 4) == 0;
            wr_note     = 6'($urandom_range(40, 63));
            wr_start    = 8'($urandom_range(0, 12));
            wr_dur      = 8'($urandom_range(0, 5));
            wr_channel  = 1'($urandom % 2);
            wr_last     = ($urandom % 5) == 0;
            frame_start = ($urandom % 12) == 0;
            run         = ($urandom % 4) != 0;
            restart     = ($urandom % 100) == 0;
            pix_valid   = ($urandom % 5) != 0;
            x = (($urandom % 8) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(88, 887));
            y = (($urandom % 8) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(32, 212));
        end

        @(negedge clk);
        wr_valid = 0; frame_start = 0; run = 0; restart = 0; pix_valid = 0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
